// File: rtl/panda_pkg.sv
// Shared types for the Panda serial comparator.
// Holds the compare-op enum, FSM states and the result decode.
package panda_pkg;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'd0,
        CMP_NE  = 3'd1,
        CMP_LT  = 3'd2,
        CMP_GE  = 3'd3,
        CMP_LTU = 3'd4,
        CMP_GEU = 3'd5
    } cmp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } cmp_state_e;

    function automatic logic cmp_is_signed(cmp_op_e op);
        return (op == CMP_LT) || (op == CMP_GE);
    endfunction

    function automatic logic cmp_result(
        cmp_op_e op,
        logic    eq,
        logic    less
    );
        logic r;
        case (op)
            CMP_EQ:           r = eq;
            CMP_NE:           r = !eq;
            CMP_LT, CMP_LTU:  r = less;
            CMP_GE, CMP_GEU:  r = !less;
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/panda_chunk_compare.sv
// Combinational compare of one operand chunk.
// Ports: a_i/b_i chunk bits, signed_i flips MSBs, eq_o/lt_o results.
module panda_chunk_compare #(
    parameter int ChunkWidth = 8
) (
    input  logic [ChunkWidth-1:0] a_i,
    input  logic [ChunkWidth-1:0] b_i,
    input  logic                  signed_i,
    output logic                  eq_o,
    output logic                  lt_o
);

    logic [ChunkWidth-1:0] msb_mask;
    logic [ChunkWidth-1:0] a_x;
    logic [ChunkWidth-1:0] b_x;

    // Flipping the sign bits maps two's complement onto unsigned order.
    always_comb begin
        msb_mask = '0;
        msb_mask[ChunkWidth-1] = signed_i;
    end

    assign a_x  = a_i ^ msb_mask;
    assign b_x  = b_i ^ msb_mask;
    assign eq_o = (a_i == b_i);
    assign lt_o = (a_x < b_x);

endmodule

// File: rtl/panda_serial_comparator.sv
// Chunk-serial RV32I compare unit, MSB chunk first, early exit.
// Ports: valid/ready in, operands+op, kill, valid/ready out, flags.
module panda_serial_comparator
    import panda_pkg::*;
#(
    parameter int Width      = 32,
    parameter int ChunkWidth = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] operand_a_i,
    input  logic [Width-1:0] operand_b_i,
    input  cmp_op_e          op_i,
    input  logic             kill_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             result_o,
    output logic             is_equal_o,
    output logic             is_less_o
);

    localparam int NumChunks = Width / ChunkWidth;
    localparam int IdxW  = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam int BaseW = (Width > 1) ? $clog2(Width) : 1;
    localparam logic [IdxW-1:0] TopIdx = IdxW'(NumChunks - 1);

    cmp_state_e state_q, state_d;

    logic [Width-1:0] a_q, a_d;
    logic [Width-1:0] b_q, b_d;
    cmp_op_e          op_q, op_d;
    logic [IdxW-1:0]  idx_q, idx_d;

    logic ready_q, ready_d;
    logic valid_q, valid_d;
    logic res_q, res_d;
    logic eq_q, eq_d;
    logic less_q, less_d;

    logic                  accept;
    logic                  scan_end;
    logic [BaseW-1:0]      base;
    logic [ChunkWidth-1:0] chunk_a;
    logic [ChunkWidth-1:0] chunk_b;
    logic                  chunk_signed;
    logic                  chunk_eq;
    logic                  chunk_lt;

    assign base    = BaseW'(32'(idx_q) * 32'(ChunkWidth));
    assign chunk_a = a_q[base +: ChunkWidth];
    assign chunk_b = b_q[base +: ChunkWidth];

    // Only the top chunk carries the sign.
    assign chunk_signed = (idx_q == TopIdx) && cmp_is_signed(op_q);

    panda_chunk_compare #(
        .ChunkWidth (ChunkWidth)
    ) u_chunk (
        .a_i      (chunk_a),
        .b_i      (chunk_b),
        .signed_i (chunk_signed),
        .eq_o     (chunk_eq),
        .lt_o     (chunk_lt)
    );

    // ready_q is the registered image of "state is IDLE", held low in reset.
    assign accept   = (state_q == ST_IDLE) && ready_q
                    && valid_i && !kill_i;
    assign scan_end = !chunk_eq || (idx_q == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_CMP;
            end
            ST_CMP: begin
                if (kill_i)        state_d = ST_IDLE;
                else if (scan_end) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (kill_i || ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        idx_d  = idx_q;
        res_d  = res_q;
        eq_d   = eq_q;
        less_d = less_q;
        if (accept) begin
            a_d   = operand_a_i;
            b_d   = operand_b_i;
            op_d  = op_i;
            idx_d = TopIdx;
        end else if (state_q == ST_CMP && !kill_i) begin
            if (scan_end) begin
                eq_d   = chunk_eq;
                less_d = !chunk_eq && chunk_lt;
                res_d  = cmp_result(op_q, chunk_eq,
                                    !chunk_eq && chunk_lt);
            end else begin
                idx_d = idx_q - IdxW'(1);
            end
        end
        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= CMP_EQ;
            idx_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            res_q   <= 1'b0;
            eq_q    <= 1'b0;
            less_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            res_q   <= res_d;
            eq_q    <= eq_d;
            less_q  <= less_d;
        end
    end

    assign ready_o    = ready_q;
    assign valid_o    = valid_q;
    assign result_o   = res_q;
    assign is_equal_o = eq_q;
    assign is_less_o  = less_q;

endmodule

// File: tb/tb_panda_serial_comparator.sv
// Bench for panda_serial_comparator: vector table, corner
// sequences and random ops against a behavioural model.
module tb_panda_serial_comparator;
    import panda_pkg::*;

    localparam int W  = 32;
    localparam int CW = 8;
    localparam int N  = W / CW;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    cmp_op_e       op = CMP_EQ;
    logic          kill_i = 1'b0;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic          result_o;
    logic          is_equal_o;
    logic          is_less_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    panda_serial_comparator #(
        .Width      (W),
        .ChunkWidth (CW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .operand_a_i (op_a),
        .operand_b_i (op_b),
        .op_i        (op),
        .kill_i      (kill_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .result_o    (result_o),
        .is_equal_o  (is_equal_o),
        .is_less_o   (is_less_o)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic         res;
        logic         eq;
        logic         less;
        int           k;
    } vec_t;

    vec_t vecs[$];

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain arithmetic on whole operands.
    function automatic logic m_less(logic [W-1:0] a, logic [W-1:0] b,
                                    logic [2:0] o);
        if (o == 3'd2 || o == 3'd3) return $signed(a) < $signed(b);
        return a < b;
    endfunction

    function automatic logic m_res(logic [W-1:0] a, logic [W-1:0] b,
                                   logic [2:0] o);
        logic eq;
        logic lt;
        eq = (a == b);
        lt = m_less(a, b, o);
        case (o)
            3'd0: return eq;
            3'd1: return !eq;
            3'd2, 3'd4: return lt;
            3'd3, 3'd5: return !lt;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int m_k(logic [W-1:0] a, logic [W-1:0] b);
        logic [W-1:0] x;
        int h;
        x = a ^ b;
        if (x == '0) return N;
        h = 0;
        for (int i = 0; i < W; i++) if (x[i]) h = i;
        return N - h / CW;
    endfunction

    task automatic issue(logic [W-1:0] a, logic [W-1:0] b,
                         logic [2:0] o);
        int t;
        t = 0;
        while (!ready_o && t < 40) begin
            tick();
            t++;
        end
        if (!ready_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got 0 want 1");
        end
        op_a    = a;
        op_b    = b;
        op      = cmp_op_e'(o);
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (cyc < 2 * N + 4) begin
            tick();
            cyc++;
            if (valid_o) break;
        end
        if (!valid_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL valid_timeout: got 0 want 1");
        end
    endtask

    task automatic run_op(string name, logic [W-1:0] a,
                          logic [W-1:0] b, logic [2:0] o,
                          logic er, logic ee, logic el,
                          int ek, int hold);
        int cyc;
        issue(a, b, o);
        wait_valid(cyc);
        check({name, "_lat"}, cyc, ek);
        check({name, "_res"}, int'(result_o), int'(er));
        check({name, "_eq"}, int'(is_equal_o), int'(ee));
        check({name, "_less"}, int'(is_less_o), int'(el));
        check({name, "_rdy_busy"}, int'(ready_o), 0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check({name, "_hold_v"}, int'(valid_o), 1);
            check({name, "_hold_r"}, int'(result_o), int'(er));
            check({name, "_hold_e"}, int'(is_equal_o), int'(ee));
            check({name, "_hold_l"}, int'(is_less_o), int'(el));
            check({name, "_hold_rdy"}, int'(ready_o), 0);
        end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check({name, "_v_drop"}, int'(valid_o), 0);
        check({name, "_rdy_back"}, int'(ready_o), 1);
    endtask

    initial begin
        int cyc;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [2:0]   ro;

        vecs.push_back('{32'd2342, 32'd53493, 3'd4, 1, 0, 1, 3});
        vecs.push_back('{32'hFFFF_FF85, 32'd53493, 3'd2, 1, 0, 1, 1});
        vecs.push_back('{32'hFFFF_FF85, 32'd53493, 3'd4, 0, 0, 0, 1});
        vecs.push_back('{32'hFFFF_A481, 32'hFFFF_A481, 3'd0, 1, 1, 0, 4});
        vecs.push_back('{32'hFFFF_A481, 32'hFFFF_A481, 3'd1, 0, 1, 0, 4});
        vecs.push_back('{32'hFFFF_A481, 32'hFFFF_A481, 3'd3, 1, 1, 0, 4});
        vecs.push_back('{32'h8000_0000, 32'd1, 3'd5, 1, 0, 0, 1});
        vecs.push_back('{32'h8000_0000, 32'd1, 3'd2, 1, 0, 1, 1});
        vecs.push_back('{32'd1, 32'hFFFF_FFFF, 3'd2, 0, 0, 0, 1});
        vecs.push_back('{32'd5, 32'd7, 3'd6, 0, 0, 1, 4});
        vecs.push_back('{32'h1234_5678, 32'h1234_5677, 3'd3, 1, 0, 0, 4});
        vecs.push_back('{32'h0012_0000, 32'h0013_0000, 3'd1, 1, 0, 1, 2});

        // Reset state
        repeat (2) tick();
        check("rst_ready", int'(ready_o), 0);
        check("rst_valid", int'(valid_o), 0);
        check("rst_res", int'(result_o), 0);
        check("rst_eq", int'(is_equal_o), 0);
        check("rst_less", int'(is_less_o), 0);
        rst_ni = 1'b1;
        tick();
        check("rst_rel_ready", int'(ready_o), 1);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].op, vecs[i].res, vecs[i].eq,
                   vecs[i].less, vecs[i].k, 0);
        end

        // Output hold under back-pressure
        run_op("hold5", 32'd2342, 32'd53493, 3'd4, 1, 0, 1, 3, 5);

        // Kill in 2nd CMP cycle
        issue(32'hFFFF_A481, 32'hFFFF_A481, 3'd0);
        check("kill_c1_v", int'(valid_o), 0);
        tick();
        kill_i = 1'b1;
        check("kill_c2_v", int'(valid_o), 0);
        tick();
        kill_i = 1'b0;
        check("kill_idle_rdy", int'(ready_o), 1);
        check("kill_idle_v", int'(valid_o), 0);
        for (int i = 0; i < N + 1; i++) begin
            tick();
            check("kill_no_pulse", int'(valid_o), 0);
        end
        run_op("after_kill", 32'd10, 32'd3, 3'd5, 1, 0, 0, 4, 0);

        // Kill blocks acceptance in IDLE
        op_a = 32'd1;
        op_b = 32'd2;
        op = CMP_LTU;
        valid_i = 1'b1;
        kill_i = 1'b1;
        tick();
        valid_i = 1'b0;
        kill_i = 1'b0;
        check("kill_idle_block", int'(ready_o), 1);
        for (int i = 0; i < N + 1; i++) begin
            tick();
            check("kill_idle_nov", int'(valid_o), 0);
        end

        // Kill together with ready_i in DONE drops the result
        issue(32'h8000_0000, 32'd0, 3'd2);
        wait_valid(cyc);
        check("kd_lat", cyc, 1);
        kill_i = 1'b1;
        ready_i = 1'b1;
        tick();
        kill_i = 1'b0;
        ready_i = 1'b0;
        check("kd_v", int'(valid_o), 0);
        check("kd_rdy", int'(ready_o), 1);

        // Reset mid-CMP
        run_op("pre_rst", 32'd77, 32'd77, 3'd0, 1, 1, 0, 4, 0);
        issue(32'd77, 32'd77, 3'd0);
        tick();
        rst_ni = 1'b0;
        tick();
        check("mrst_ready", int'(ready_o), 0);
        check("mrst_valid", int'(valid_o), 0);
        check("mrst_res", int'(result_o), 0);
        check("mrst_eq", int'(is_equal_o), 0);
        check("mrst_less", int'(is_less_o), 0);
        rst_ni = 1'b1;
        tick();
        check("mrst_rel_rdy", int'(ready_o), 1);
        run_op("post_rst", 32'hFFFF_FFFE, 32'd3, 3'd3, 0, 0, 1, 1, 0);

        // Randomized against the model
        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (32'd1 << $urandom_range(0, 31));
                2: rb = {ra[31:16], 16'($urandom)};
                default: rb = $urandom;
            endcase
            ro = 3'($urandom_range(0, 7));
            run_op($sformatf("rnd%0d", i), ra, rb, ro,
                   m_res(ra, rb, ro), ra == rb,
                   (ra != rb) && m_less(ra, rb, ro),
                   m_k(ra, rb), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/panda_serial_comparator.md
# panda_serial_comparator

Multi-cycle, area-reduced comparator for the Panda core that evaluates all RV32I compare conditions (BEQ/BNE/BLT/BGE/BLTU/BGEU, SLT/SLTU) by scanning operands `ChunkWidth` bits per cycle, MSB chunk first, and terminating at the first differing chunk. It extends the single-cycle subtract-based comparator with:

- parametrised operand width and chunk width,
- a valid/ready handshake on input and output,
- variable latency,
- a kill input for pipeline flush.

It is intended for area-constrained Panda configurations, sitting between the register-read stage and branch resolution.

## Interface
Parameters:
- `Width`, 32, operand width in bits.
- `ChunkWidth`, 8, bits compared per cycle; must divide `Width`. `NumChunks = Width/ChunkWidth` is derived.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset; one clock; reset is synchronous and active-low.
- `valid_i`  in  1  operands and op valid.
- `ready_o`  out  1  unit can accept.
- `operand_a_i`  in  Width  operand A.
- `operand_b_i`  in  Width  operand B.
- `op_i`  in  `cmp_op_e`  EQ, NE, LT, GE, LTU, GEU.
- `kill_i`  in  1  abort the in-flight operation.
- `valid_o`  out  1  result valid.
- `ready_i`  in  1  consumer accepts the result.
- `result_o`  out  1  condition outcome for `op_i`.
- `is_equal_o`  out  1  A == B.
- `is_less_o`  out  1  A < B, signed for LT/GE and unsigned for LTU/GEU.

## Operation
FSM states are IDLE, CMP and DONE.

- **IDLE:** `ready_o`=1. On `valid_i` the unit latches A, B and op, sets chunk index to `NumChunks-1`, and moves to CMP.
- **CMP:** each cycle compares chunk[idx] of A and B.
  - For the top chunk under LT/GE, the chunk MSBs are inverted before an unsigned compare, which gives signed ordering.
  - If the chunks differ, the unit registers `is_less_o` from the chunk compare and `is_equal_o`=0, then moves to DONE.
  - If the chunks are equal and idx==0, it registers `is_equal_o`=1 and `is_less_o`=0, then moves to DONE.
  - Otherwise it decrements idx.
- **DONE:** `valid_o`=1. On `ready_i` it returns to IDLE. Outputs hold stable while `ready_i`=0.

`result_o` decode:
- EQ = eq
- NE = !eq
- LT and LTU = less
- GE and GEU = !less
- Undefined op encodings give `result_o`=0.

`kill_i` in CMP or DONE moves the FSM to IDLE on the next edge, with no `valid_o` pulse. In IDLE, `kill_i` blocks acceptance that cycle, and `kill_i` takes priority over `valid_i`.

If `ChunkWidth==Width`, the unit degenerates to exactly one CMP cycle.

## Timing
- Reset values: state IDLE, idx 0, `valid_o`=0, `result_o`=0, `is_equal_o`=0, `is_less_o`=0. `ready_o`=0 while `rst_ni`=0, and 1 in the first cycle after reset is released.
- Acceptance occurs on the edge where `valid_i`&&`ready_o`. `valid_o` rises k cycles later, where k is the number of chunks scanned (1..`NumChunks`). Equal operands always take `NumChunks` cycles.
- A result leaves on the edge with `valid_o`&&`ready_i`. `ready_o` rises in the following cycle, so there is no input/output overlap. Minimum issue interval is k+2 cycles.
- Reset mid-operation discards the operation: the next cycle is IDLE with all outputs at their reset values.
- `kill_i` and `ready_i` asserted together in DONE count as a kill: the result is dropped.
- All outputs are registered. `ready_o` is decoded from state only.

## Structure
- `panda_pkg` holds `cmp_op_e` (3-bit enum: EQ, NE, LT, GE, LTU, GEU) and the FSM state typedef.
- The sub-module is `panda_chunk_compare`, a combinational `ChunkWidth`-bit compare. Its inputs are a, b, `signed_i` (asserted only for the top chunk under LT/GE). Its outputs are `eq_o` and `lt_o`.
- The top level holds the FSM, operand/op registers, the chunk index counter and the output registers. Chunk selection is an indexed part-select on the latched operands.

## Test plan
All cases use Width=32, ChunkWidth=8.

1. A=2342, B=53493, LTU: first difference at chunk 1 -> `valid_o` after 3 cycles, `is_less_o`=1, `result_o`=1.
2. A=-123, B=53493, LT -> k=1, `is_less_o`=1, `result_o`=1. The same operands with LTU -> k=1, `is_less_o`=0, `result_o`=0.
3. A=B=-23423, EQ then NE -> each k=4, `is_equal_o`=1, results 1 then 0. GE on the same operands -> `result_o`=1.
4. Hold `ready_i`=0 for 5 cycles in DONE -> `valid_o` and all outputs are stable, `ready_o`=0. Release -> `ready_o`=1 on the next cycle.
5. Pulse `kill_i` in the 2nd CMP cycle of an EQ on equal operands -> no `valid_o` pulse, IDLE next cycle. A new op is accepted immediately after.
6. Assert `rst_ni`=0 mid-CMP -> next cycle all outputs are 0 and `ready_o`=0. After release, `ready_o`=1 and the next op completes normally.
